// File: rtl/a2bus_write_capture.sv
// a2bus_write_capture
// Queues sampled Apple II bus cycles whose address falls inside a configured
// window into a show-ahead FIFO, so card logic can service them later over a
// valid/ready handshake instead of inside the strobe cycle.
//
// Ports:
//   clk_logic, device_reset_n    : logic clock, async active-low reset
//   data_in_strobe_i             : one-cycle pulse, addr_i/data_i/rw_n_i valid
//   addr_i, data_i, rw_n_i       : sampled bus cycle
//   evt_valid_o/evt_ready_i      : head-entry handshake
//   evt_addr_o/data_o/rw_n_o     : head entry fields (zero/1 while empty)
//   level_o                      : entry count 0..DEPTH
//   overflow_o, overflow_clr_i   : sticky drop flag and its clear
//   drop_count_o                 : saturating drop counter
//
// Optional feature: define A2BUS_CAPTURE_DROP_COUNT_EN to build the 16-bit
// drop counter; otherwise drop_count_o is tied to zero.
module a2bus_write_capture #(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] ADDR_MATCH    = 16'hC0B0,
  parameter logic [15:0] ADDR_MASK     = 16'hFFF0,
  parameter bit          CAPTURE_READS = 1'b0,
  localparam int         AW            = $clog2(DEPTH)
) (
  input  logic          clk_logic,
  input  logic          device_reset_n,
  input  logic          data_in_strobe_i,
  input  logic [15:0]   addr_i,
  input  logic [7:0]    data_i,
  input  logic          rw_n_i,
  output logic          evt_valid_o,
  input  logic          evt_ready_i,
  output logic [15:0]   evt_addr_o,
  output logic [7:0]    evt_data_o,
  output logic          evt_rw_n_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  input  logic          overflow_clr_i,
  output logic [15:0]   drop_count_o
);

  // Entry layout: {addr[15:0], data[7:0], rw_n}
  logic [24:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;

  logic qualify, empty, full, push, pop, drop;
  logic [24:0] head;

  always_comb begin
    qualify = data_in_strobe_i &&
              ((addr_i & ADDR_MASK) == ADDR_MATCH) &&
              (!rw_n_i || CAPTURE_READS);
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // pop depends only on registered state plus ready; it never feeds the
    // head outputs combinationally.
    pop     = !empty && evt_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push    = qualify && (!full || pop);
    drop    = qualify && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Set beats clear.
    overflow_d = overflow_q;
    if (overflow_clr_i) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset: emptiness is defined by the pointers alone, and
  // head outputs are forced to their idle values while empty.
  always_ff @(posedge clk_logic) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {addr_i, data_i, rw_n_i};
  end

  always_comb begin
    head        = mem_q[rd_ptr_q[AW-1:0]];
    evt_valid_o = !empty;
    evt_addr_o  = empty ? 16'h0000 : head[24:9];
    evt_data_o  = empty ? 8'h00    : head[8:1];
    evt_rw_n_o  = empty ? 1'b1     : head[0];
    level_o     = wr_ptr_q - rd_ptr_q;
    overflow_o  = overflow_q;
  end

`ifdef A2BUS_CAPTURE_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr_i) begin
      // A drop coinciding with the clear counts as the first new drop.
      drop_cnt_d = drop ? 16'h0001 : 16'h0000;
    end else if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) drop_cnt_q <= 16'h0000;
    else                 drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_a2bus_write_capture.sv
// Directed bench for a2bus_write_capture with default parameters
// (DEPTH 16, window C0B0..C0BF, writes only).
module tb_a2bus_write_capture;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw_n;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_addr;
  logic [7:0]  evt_data;
  logic        evt_rw_n;
  logic [4:0]  level;
  logic        overflow;
  logic        ovf_clr;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  a2bus_write_capture dut (
    .clk_logic        (clk),
    .device_reset_n   (rst_n),
    .data_in_strobe_i (strobe),
    .addr_i           (addr),
    .data_i           (data),
    .rw_n_i           (rw_n),
    .evt_valid_o      (evt_valid),
    .evt_ready_i      (evt_ready),
    .evt_addr_o       (evt_addr),
    .evt_data_o       (evt_data),
    .evt_rw_n_o       (evt_rw_n),
    .level_o          (level),
    .overflow_o       (overflow),
    .overflow_clr_i   (ovf_clr),
    .drop_count_o     (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    strobe = 1'b1; addr = a; data = d; rw_n = 1'b0;
    step();
    strobe = 1'b0;
  endtask

  logic [24:0] model_q[$];
  logic [24:0] exp_e;
  int sent, recvd, cyc;
  logic do_push, do_pop;
  logic [15:0] exp_drops;

  initial begin
    rst_n = 1'b0; strobe = 1'b0; addr = '0; data = '0; rw_n = 1'b1;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    check("rst_valid", evt_valid, 0);
    check("rst_addr", evt_addr, 0);
    check("rst_data", evt_data, 0);
    check("rst_rw_n", evt_rw_n, 1);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drops", drop_count, 0);
    rst_n = 1'b1;
    step();

    // Single write, then pop.
    wr(16'hC0B3, 8'h5A);
    check("one_valid", evt_valid, 1);
    check("one_addr", evt_addr, 16'hC0B3);
    check("one_data", evt_data, 8'h5A);
    check("one_rw_n", evt_rw_n, 0);
    check("one_level", level, 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("pop_valid", evt_valid, 0);
    check("pop_level", level, 0);

    // Filtering.
    wr(16'hC0C0, 8'h01);
    check("flt_out_of_window", level, 0);
    strobe = 1'b1; addr = 16'hC0B0; data = 8'h02; rw_n = 1'b1;
    step();
    strobe = 1'b0;
    check("flt_read", level, 0);
    wr(16'hC0BF, 8'h03);
    check("flt_top_level", level, 1);
    check("flt_top_addr", evt_addr, 16'hC0BF);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("flt_drained", level, 0);

    // Fill past capacity.
    for (int i = 0; i < DEPTH + 3; i++) wr(16'hC0B0 | 16'(i & 15), 8'(i));
`ifdef A2BUS_CAPTURE_DROP_COUNT_EN
    exp_drops = 16'd3;
`else
    exp_drops = 16'd0;
`endif
    check("fill_level", level, DEPTH);
    check("fill_ovf", overflow, 1);
    check("fill_drops", drop_count, exp_drops);
    check("fill_head", evt_data, 8'h00);

    // Full: push and pop together.
    strobe = 1'b1; addr = 16'hC0B5; data = 8'hEE; rw_n = 1'b0; evt_ready = 1'b1;
    step();
    strobe = 1'b0; evt_ready = 1'b0;
    check("fullpp_level", level, DEPTH);
    check("fullpp_ovf", overflow, 1);
    check("fullpp_drops", drop_count, exp_drops);

    // Drop coinciding with clear: set wins.
    ovf_clr = 1'b1;
    wr(16'hC0B6, 8'hDD);
`ifdef A2BUS_CAPTURE_DROP_COUNT_EN
    exp_drops = 16'd1;
`else
    exp_drops = 16'd0;
`endif
    check("prec_ovf", overflow, 1);
    check("prec_drops", drop_count, exp_drops);
    step();
    ovf_clr = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_drops", drop_count, 0);

    // Drain: entries 1..15 of the fill, then the EE pushed while full.
    evt_ready = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      check("drain_valid", evt_valid, 1);
      check("drain_data", evt_data, (k == DEPTH) ? 8'hEE : 8'(k));
      check("drain_addr", evt_addr, (k == DEPTH) ? 16'hC0B5 : (16'hC0B0 | 16'(k & 15)));
      step();
    end
    evt_ready = 1'b0;
    check("drain_empty", level, 0);

    // Wrap: 3*DEPTH+5 events with random ready, against a queue model.
    sent = 0; recvd = 0; cyc = 0;
    while (recvd < 3 * DEPTH + 5 && cyc < 4000) begin
      evt_ready = 1'($urandom_range(0, 1));
      do_pop  = evt_ready && (model_q.size() != 0);
      do_push = (sent < 3 * DEPTH + 5) && ($urandom_range(0, 3) != 0) &&
                (model_q.size() < DEPTH || do_pop);
      strobe = do_push;
      addr   = 16'hC0B0 | 16'(sent & 15);
      data   = 8'(sent) ^ 8'hA5;
      rw_n   = 1'b0;
      if (do_pop) begin
        exp_e = model_q.pop_front();
        check("wrap_entry", {evt_valid, evt_addr, evt_data, evt_rw_n}, {1'b1, exp_e});
        recvd++;
      end
      if (do_push) begin
        model_q.push_back({addr, data, rw_n});
        sent++;
      end
      step();
      cyc++;
      check("wrap_level", level, model_q.size());
    end
    strobe = 1'b0; evt_ready = 1'b0;
    check("wrap_count", recvd, 3 * DEPTH + 5);

    // Reset with entries queued.
    for (int i = 0; i < 4; i++) wr(16'hC0B8, 8'(8'h40 + i));
    check("prerst_level", level, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", evt_valid, 0);
    check("arst_level", level, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_valid", evt_valid, 0);
    check("post_level", level, 0);
    wr(16'hC0B9, 8'h77);
    check("post_new_data", evt_data, 8'h77);
    check("post_new_level", level, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
